// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and constants for the function-decoder sweep controller.
// Holds the FSM encoding, golden truth tables and counter/table widths.
package tt_sweep_ctrl_pkg;

  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned TT_W     = 8;
  localparam int unsigned F_W      = 3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  // Golden truth tables, bit n = minterm n
  localparam logic [TT_W-1:0] EXP_F1 = 8'h94;
  localparam logic [TT_W-1:0] EXP_F2 = 8'h09;
  localparam logic [TT_W-1:0] EXP_F3 = 8'h9D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TT_W-1:0] f3;
    logic [TT_W-1:0] f2;
    logic [TT_W-1:0] f1;
  } tt_set_t;

  localparam tt_set_t GOLD_TT = '{f3: EXP_F3, f2: EXP_F2, f1: EXP_F1};

  // Per-minterm mismatch of any of the three captured tables
  function automatic logic [TT_W-1:0] tt_fail_mask(input tt_set_t tt, input tt_set_t gold);
    return (tt.f1 ^ gold.f1) | (tt.f2 ^ gold.f2) | (tt.f3 ^ gold.f3);
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Loadable down-counter that times how long a minterm is held before sampling.
// expire_c flags the last settle cycle of the current load.
module tt_sweep_ctrl_settle_timer
  import tt_sweep_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expire_c
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // Saturate at zero so a stray enable never wraps the counter
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Built-in self-check sequencer for the 3-input function decoder: walks all
// 8 minterms, captures F[3:1] into truth tables and compares against golden.
module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] dut_i,
  input  logic [F_W-1:0]   dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TT_W-1:0]  tt_f1,
  output logic [TT_W-1:0]  tt_f2,
  output logic [TT_W-1:0]  tt_f3,
  output logic [TT_W-1:0]  fail_mask
);

  localparam int unsigned SETTLE_MAX = (2 ** SETTLE_W) - 1;
  localparam int unsigned SETTLE_CLAMP =
    (SETTLE_CYCLES == 0) ? 1 : ((SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CLAMP);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tt_set_t          tt_q, tt_d;
  logic [TT_W-1:0]  fail_mask_q, fail_mask_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] dut_i_q, dut_i_d;

  logic tmr_load_c;
  logic tmr_en_c;
  logic tmr_expire_c;

  tt_sweep_ctrl_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .en       (tmr_en_c),
    .load_val (SETTLE_LOAD),
    .expire_c (tmr_expire_c)
  );

  // Next-state, capture and compare; outputs derived from the next state so they are registered
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tt_d        = tt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    tmr_load_c  = 1'b0;
    tmr_en_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_DRIVE;
          idx_d       = '0;
          tt_d        = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          tmr_load_c  = 1'b1;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          fail_mask_d = '0;
          pass_d      = 1'b0;
        end else if (tmr_expire_c) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en_c = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          fail_mask_d = '0;
          pass_d      = 1'b0;
        end else begin
          tt_d.f1[idx_q] = dut_f[0];
          tt_d.f2[idx_q] = dut_f[1];
          tt_d.f3[idx_q] = dut_f[2];
          if (idx_q == IDX_LAST) begin
            // Compare on entry to CHECK so results are valid in the done cycle
            state_d     = ST_CHECK;
            fail_mask_d = tt_fail_mask(tt_d, GOLD_TT);
            pass_d      = (fail_mask_d == '0);
          end else begin
            state_d    = ST_DRIVE;
            idx_d      = idx_q + IDX_W'(1);
            tmr_load_c = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_CHECK);
    dut_i_d = ((state_d == ST_DRIVE) || (state_d == ST_SAMPLE)) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tt_q        <= '0;
      fail_mask_q <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_i_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tt_q        <= tt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_i_q     <= dut_i_d;
    end
  end

  assign dut_i     = dut_i_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign tt_f1     = tt_q.f1;
  assign tt_f2     = tt_q.f2;
  assign tt_f3     = tt_q.f3;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (settle 1 and 3 cycles) against a
// cycle-timing reference model, with a done-triggered result scoreboard.
module tb_tt_sweep_ctrl;

  localparam int N_INST = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic fault;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] t1;
    logic [7:0] t2;
    logic [7:0] t3;
    logic [7:0] fm;
    logic       pass;
    int         cyc;
  } res_t;

  always #5 clk = ~clk;

  // Decoder truth: F1 = minterms {2,4,7}, F2 = {0,3}, F3 = F1|F2; fault forces F2 low
  function automatic logic [2:0] dec_model(input logic [2:0] m, input logic f2_stuck);
    logic f1, f2, f3;
    f1 = (m == 3'd2) || (m == 3'd4) || (m == 3'd7);
    f2 = (m == 3'd0) || (m == 3'd3);
    f3 = f1 | f2;
    if (f2_stuck) f2 = 1'b0;
    return {f3, f2, f1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int S     = (g == 0) ? 1 : 3;
    localparam int P     = S + 1;
    localparam int TDONE = 8 * P + 1;

    logic [2:0] dut_i;
    logic [2:0] dut_f;
    logic       busy, done, pass;
    logic [7:0] tt_f1, tt_f2, tt_f3, fail_mask;

    tt_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .dut_i     (dut_i),
      .dut_f     (dut_f),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .tt_f1     (tt_f1),
      .tt_f2     (tt_f2),
      .tt_f3     (tt_f3),
      .fail_mask (fail_mask)
    );

    always_comb dut_f = dec_model(dut_i, fault);

    // Reference: m_t is the cycle number within a sweep (1..TDONE)
    bit         m_act = 1'b0;
    int         m_t = 0;
    int         m_cyc = 0;
    int         m_done_at = 0;
    logic [7:0] m_t1 = '0, m_t2 = '0, m_t3 = '0, m_fm = '0;
    logic       m_pass = 1'b0;
    res_t       q[$];

    always @(posedge clk or negedge rst_n) begin : p_model
      logic [2:0] f;
      int         n;
      res_t       r;
      if (!rst_n) begin
        m_act = 1'b0; m_t = 0;
        m_t1 = '0; m_t2 = '0; m_t3 = '0; m_fm = '0; m_pass = 1'b0;
        q.delete();
      end else begin
        m_cyc++;
        if (!m_act) begin
          if (start && !abort) begin
            m_act = 1'b1; m_t = 1;
            m_t1 = '0; m_t2 = '0; m_t3 = '0; m_fm = '0; m_pass = 1'b0;
            m_done_at = m_cyc + TDONE - 1;
          end
        end else if (m_t == TDONE) begin
          m_act = 1'b0;
        end else if (abort) begin
          m_act = 1'b0; m_fm = '0; m_pass = 1'b0;
        end else begin
          if ((m_t % P) == 0) begin
            n = m_t / P - 1;
            f = dec_model(3'(n), fault);
            m_t1[n] = f[0]; m_t2[n] = f[1]; m_t3[n] = f[2];
          end
          m_t++;
          if (m_t == TDONE) begin
            m_fm   = (m_t1 ^ 8'h94) | (m_t2 ^ 8'h09) | (m_t3 ^ 8'h9D);
            m_pass = (m_fm == 8'h00);
            r.t1 = m_t1; r.t2 = m_t2; r.t3 = m_t3; r.fm = m_fm; r.pass = m_pass;
            r.cyc = m_done_at;
            q.push_back(r);
          end
        end
      end
    end

    // Monitor: per-cycle outputs against the model, scoreboard pop on done
    initial begin : p_mon
      res_t       r;
      logic [2:0] e_i;
      forever begin
        @(posedge clk);
        #1;
        e_i = (m_act && (m_t < TDONE)) ? 3'((m_t - 1) / P) : 3'd0;
        check($sformatf("i%0d busy", g), 32'(busy), 32'(m_act));
        check($sformatf("i%0d done", g), 32'(done), 32'(m_act && (m_t == TDONE)));
        check($sformatf("i%0d dut_i", g), 32'(dut_i), 32'(e_i));
        check($sformatf("i%0d pass", g), 32'(pass), 32'(m_pass));
        check($sformatf("i%0d fail_mask", g), 32'(fail_mask), 32'(m_fm));
        check($sformatf("i%0d tt_f1", g), 32'(tt_f1), 32'(m_t1));
        check($sformatf("i%0d tt_f2", g), 32'(tt_f2), 32'(m_t2));
        check($sformatf("i%0d tt_f3", g), 32'(tt_f3), 32'(m_t3));
        if (done === 1'b1) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL i%0d sb_done: got done=1 at cycle %0d, expected no result pending", g, m_cyc);
          end else begin
            r = q.pop_front();
            check($sformatf("i%0d sb_cycle", g), 32'(m_cyc), 32'(r.cyc));
            check($sformatf("i%0d sb_tt_f1", g), 32'(tt_f1), 32'(r.t1));
            check($sformatf("i%0d sb_tt_f2", g), 32'(tt_f2), 32'(r.t2));
            check($sformatf("i%0d sb_tt_f3", g), 32'(tt_f3), 32'(r.t3));
            check($sformatf("i%0d sb_fail_mask", g), 32'(fail_mask), 32'(r.fm));
            check($sformatf("i%0d sb_pass", g), 32'(pass), 32'(r.pass));
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (((g_dut[0].busy !== 1'b0) || (g_dut[1].busy !== 1'b0)) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= budget) begin
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fault = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(g_dut[0].busy), 32'(0));
    check("reset dut_i", 32'(g_dut[1].dut_i), 32'(0));
    check("reset tt_f1", 32'(g_dut[0].tt_f1), 32'(0));

    // Nominal sweep
    pulse_start();
    wait_idle(200);
    check("nom tt_f1", 32'(g_dut[0].tt_f1), 32'(8'h94));
    check("nom tt_f2", 32'(g_dut[0].tt_f2), 32'(8'h09));
    check("nom tt_f3", 32'(g_dut[0].tt_f3), 32'(8'h9D));
    check("nom pass s1", 32'(g_dut[0].pass), 32'(1));
    check("nom pass s3", 32'(g_dut[1].pass), 32'(1));

    // F2 stuck at zero
    fault = 1'b1;
    pulse_start();
    wait_idle(200);
    fault = 1'b0;
    check("flt tt_f2", 32'(g_dut[0].tt_f2), 32'(8'h00));
    check("flt fail_mask s1", 32'(g_dut[0].fail_mask), 32'(8'h09));
    check("flt fail_mask s3", 32'(g_dut[1].fail_mask), 32'(8'h09));
    check("flt pass", 32'(g_dut[0].pass), 32'(0));

    // Start held high across several sweeps
    start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    wait_idle(200);

    // Abort during SAMPLE of minterm 4 (cycle 10 for settle 1)
    pulse_start();
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(g_dut[0].busy), 32'(0));
    check("abort pass", 32'(g_dut[0].pass), 32'(0));
    wait_idle(200);
    pulse_start();
    wait_idle(200);
    check("post-abort pass", 32'(g_dut[0].pass), 32'(1));

    // Reset mid-sweep at minterm 5, then a settle-3 sweep
    pulse_start();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy s1", 32'(g_dut[0].busy), 32'(0));
    check("midrst busy s3", 32'(g_dut[1].busy), 32'(0));
    check("midrst dut_i", 32'(g_dut[0].dut_i), 32'(0));
    check("midrst tt_f1", 32'(g_dut[0].tt_f1), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_idle(200);
    check("s3 pass", 32'(g_dut[1].pass), 32'(1));

    // Random start/abort/fault traffic
    repeat (800) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      fault = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    fault = 1'b0;
    wait_idle(200);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
